// File: rtl/in_service_control.sv
// In-service control for an 8-level interrupt controller: INTA handshake FSM, ISR, EOI and priority rotation.
// Optional auto-EOI (auto_eoi port and ISR clear on the final INTA) is enabled by defining ISC_AUTO_EOI_EN.
module in_service_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] interrupt,
  input  logic       interrupt_acknowledge_n,
  input  logic       end_of_interrupt,
  input  logic       specific_eoi,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  input  logic [4:0] vector_base,
`ifdef ISC_AUTO_EOI_EN
  input  logic       auto_eoi,
`endif
  output logic       int_out,
  output logic [7:0] interrupt_request_clear,
  output logic [7:0] in_service_register,
  output logic [2:0] priority_rotate,
  output logic [7:0] data_out,
  output logic       data_out_en,
  output logic [1:0] debug_state
);

  // Handshake: one request per sequence; INTA is level-sampled, edges come from inta_q vs current.
  typedef enum logic [1:0] {IDLE, REQ, ACK1, ACK2} state_t;

  state_t     state;
  logic       inta_q;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] level;
  logic       spurious;
  logic [2:0] irq_level;
  logic       eoi_hit;
  logic [2:0] eoi_lvl;
  logic [2:0] scan_idx;
  logic       auto_hit;
  logic       set_hit;
  logic [7:0] clear_mask;
  logic [7:0] set_mask;
  logic [7:0] isr_next;

  assign debug_state = state;
  assign inta_fall   = inta_q & ~interrupt_acknowledge_n;
  assign inta_rise   = ~inta_q & interrupt_acknowledge_n;

  always_comb begin
    irq_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (interrupt[i]) irq_level = 3'(i);
    end
  end

  // Non-specific EOI scans from the level after the lowest-priority one, wrapping; the rotate level is last.
  always_comb begin
    eoi_hit  = 1'b0;
    eoi_lvl  = 3'd0;
    scan_idx = 3'd0;
    if (end_of_interrupt) begin
      if (specific_eoi) begin
        eoi_lvl = eoi_level;
        eoi_hit = in_service_register[eoi_level];
      end else begin
        for (int i = 1; i <= 8; i++) begin
          scan_idx = priority_rotate + 3'(i);
          if (!eoi_hit && in_service_register[scan_idx]) begin
            eoi_hit = 1'b1;
            eoi_lvl = scan_idx;
          end
        end
      end
    end
  end

`ifdef ISC_AUTO_EOI_EN
  assign auto_hit = (state == ACK2) && inta_rise && auto_eoi && !spurious && in_service_register[level];
`else
  assign auto_hit = 1'b0;
`endif

  assign set_hit    = (state == REQ) && inta_fall && (interrupt != 8'd0);
  assign set_mask   = set_hit ? (8'd1 << irq_level) : 8'd0;
  assign clear_mask = (eoi_hit ? (8'd1 << eoi_lvl) : 8'd0) | (auto_hit ? (8'd1 << level) : 8'd0);
  // Set is applied after clear so a same-cycle set of the EOI'd bit wins.
  assign isr_next   = (in_service_register & ~clear_mask) | set_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= IDLE;
      inta_q                  <= 1'b1;
      int_out                 <= 1'b0;
      interrupt_request_clear <= 8'd0;
      in_service_register     <= 8'd0;
      priority_rotate         <= 3'b111;
      data_out                <= 8'd0;
      data_out_en             <= 1'b0;
      level                   <= 3'd0;
      spurious                <= 1'b0;
    end else begin
      inta_q                  <= interrupt_acknowledge_n;
      interrupt_request_clear <= 8'd0;
      in_service_register     <= isr_next;
      if (rotate_on_eoi && eoi_hit) priority_rotate <= eoi_lvl;
      else if (rotate_on_eoi && auto_hit) priority_rotate <= level;
      case (state)
        IDLE: begin
          if (interrupt != 8'd0) begin
            state   <= REQ;
            int_out <= 1'b1;
          end
        end
        REQ: begin
          if (inta_fall) begin
            state   <= ACK1;
            int_out <= 1'b0;
            if (interrupt != 8'd0) begin
              level                   <= irq_level;
              spurious                <= 1'b0;
              interrupt_request_clear <= 8'd1 << irq_level;
            end else begin
              level    <= 3'd7;
              spurious <= 1'b1;
            end
          end
        end
        ACK1: begin
          // Entered with INTA low, so the next fall is necessarily preceded by a rise.
          if (inta_fall) begin
            state       <= ACK2;
            data_out    <= {vector_base, level};
            data_out_en <= 1'b1;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            state       <= IDLE;
            data_out_en <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_in_service_control.sv
// Randomized bench for in_service_control against a transaction-level ISR/priority model.
module tb_in_service_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] interrupt = 8'd0;
  logic       interrupt_acknowledge_n = 1'b1;
  logic       end_of_interrupt = 1'b0;
  logic       specific_eoi = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       rotate_on_eoi = 1'b0;
  logic [4:0] vector_base = 5'd0;
`ifdef ISC_AUTO_EOI_EN
  logic       auto_eoi = 1'b0;
`endif
  logic       int_out;
  logic [7:0] interrupt_request_clear;
  logic [7:0] in_service_register;
  logic [2:0] priority_rotate;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [1:0] debug_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_isr;
  int         m_pr;
  logic [7:0] m_dout;

  in_service_control dut (
    .clk(clk),
    .rst(rst),
    .interrupt(interrupt),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .end_of_interrupt(end_of_interrupt),
    .specific_eoi(specific_eoi),
    .eoi_level(eoi_level),
    .rotate_on_eoi(rotate_on_eoi),
    .vector_base(vector_base),
`ifdef ISC_AUTO_EOI_EN
    .auto_eoi(auto_eoi),
`endif
    .int_out(int_out),
    .interrupt_request_clear(interrupt_request_clear),
    .in_service_register(in_service_register),
    .priority_rotate(priority_rotate),
    .data_out(data_out),
    .data_out_en(data_out_en),
    .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference EOI: specific clears the named level; non-specific takes the first set level after m_pr.
  task automatic model_eoi(input bit spec, input int lvl, input bit rot);
    int hit = -1;
    if (spec) begin
      if (m_isr[lvl]) hit = lvl;
    end else begin
      for (int i = 1; i <= 8; i++) begin
        int k = (m_pr + i) % 8;
        if (hit < 0 && m_isr[k]) hit = k;
      end
    end
    if (hit >= 0) begin
      m_isr[hit] = 1'b0;
      if (rot) m_pr = hit;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_int_out"}, int_out, 0);
    check({tag, "_clr"}, interrupt_request_clear, 0);
    check({tag, "_isr"}, in_service_register, 0);
    check({tag, "_pr"}, priority_rotate, 7);
    check({tag, "_dout"}, data_out, 0);
    check({tag, "_en"}, data_out_en, 0);
  endtask

  task automatic do_reset();
    interrupt = 8'd0;
    interrupt_acknowledge_n = 1'b1;
    end_of_interrupt = 1'b0;
    rst = 1'b0;
    #1;
    m_isr = 8'd0;
    m_pr = 7;
    m_dout = 8'd0;
    check_reset_values("reset");
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic do_eoi(input bit spec, input int lvl, input bit rot);
    end_of_interrupt = 1'b1;
    specific_eoi = spec;
    eoi_level = 3'(lvl);
    rotate_on_eoi = rot;
    tick();
    end_of_interrupt = 1'b0;
    model_eoi(spec, lvl, rot);
    check("eoi_isr", in_service_register, m_isr);
    check("eoi_pr", priority_rotate, m_pr);
  endtask

  // Full two-pulse INTA sequence; irq_ack is the request present at the first falling edge (0 = spurious).
  task automatic run_seq(input logic [7:0] irq_ack, input logic [4:0] vb, input bit co_eoi,
                         input bit co_spec, input int co_lvl, input bit co_rot);
    int lvl = 7;
    bit spur = (irq_ack == 8'd0);
    for (int i = 0; i < 8; i++) if (irq_ack[i]) lvl = i;
    check("idle_dout", data_out, m_dout);
    check("idle_en", data_out_en, 0);
    interrupt = spur ? 8'h10 : irq_ack;
    vector_base = vb;
    tick();
    check("req_int_out", int_out, 1);
    interrupt = irq_ack;
    tick();
    check("req_hold", int_out, 1);
    check("req_en", data_out_en, 0);
    interrupt_acknowledge_n = 1'b0;
    if (co_eoi) begin
      end_of_interrupt = 1'b1;
      specific_eoi = co_spec;
      eoi_level = 3'(co_lvl);
      rotate_on_eoi = co_rot;
    end
    tick();
    end_of_interrupt = 1'b0;
    if (co_eoi) model_eoi(co_spec, co_lvl, co_rot);
    if (!spur) m_isr[lvl] = 1'b1;
    check("ack1_clr", interrupt_request_clear, spur ? 8'd0 : irq_ack);
    check("ack1_isr", in_service_register, m_isr);
    check("ack1_pr", priority_rotate, m_pr);
    check("ack1_int_out", int_out, 0);
    interrupt = 8'd0;
    tick();
    check("clr_once", interrupt_request_clear, 0);
    interrupt_acknowledge_n = 1'b1;
    tick();
    tick();
    check("ack1_en", data_out_en, 0);
    interrupt_acknowledge_n = 1'b0;
    tick();
    m_dout = {vb, 3'(lvl)};
    check("ack2_en", data_out_en, 1);
    check("ack2_dout", data_out, m_dout);
    tick();
    check("ack2_en_hold", data_out_en, 1);
    interrupt_acknowledge_n = 1'b1;
    tick();
`ifdef ISC_AUTO_EOI_EN
    if (auto_eoi && !spur && m_isr[lvl]) begin
      m_isr[lvl] = 1'b0;
      if (rotate_on_eoi) m_pr = lvl;
    end
`endif
    check("done_en", data_out_en, 0);
    check("done_dout", data_out, m_dout);
    check("done_isr", in_service_register, m_isr);
    check("done_pr", priority_rotate, m_pr);
    tick();
  endtask

  initial begin
    m_isr = 8'd0;
    m_pr = 7;
    m_dout = 8'd0;
    #3;
    do_reset();

    // Basic vector: level 2 with base 01000 gives 0x42.
    run_seq(8'h04, 5'b01000, 0, 0, 0, 0);
    check("vec42_dout", data_out, 8'h42);
    check("vec42_isr", in_service_register, 8'h04);

    // Non-specific EOI with default rotation.
    do_reset();
    run_seq(8'h02, 5'd3, 0, 0, 0, 0);
    run_seq(8'h80, 5'd3, 0, 0, 0, 0);
    do_eoi(0, 0, 0);
    check("nseoi_pr7", in_service_register, 8'h80);

    // Same ISR with the lowest priority at level 0.
    do_reset();
    run_seq(8'h01, 5'd1, 0, 0, 0, 0);
    do_eoi(1, 0, 1);
    check("pr_is_0", priority_rotate, 0);
    run_seq(8'h02, 5'd1, 0, 0, 0, 0);
    run_seq(8'h80, 5'd1, 0, 0, 0, 0);
    do_eoi(0, 0, 0);
    check("nseoi_pr0", in_service_register, 8'h80);

    // Specific EOI with rotation, then EOI on an empty ISR.
    do_reset();
    run_seq(8'h20, 5'd9, 0, 0, 0, 0);
    do_eoi(1, 5, 1);
    check("seoi_isr", in_service_register, 8'h00);
    check("seoi_pr", priority_rotate, 5);
    do_eoi(0, 0, 1);
    do_eoi(1, 3, 1);

    // Spurious acknowledge.
    run_seq(8'h00, 5'b10101, 0, 0, 0, 0);
    check("spur_dout", data_out, 8'hAF);

    // EOI and set of the same bit in one cycle.
    do_reset();
    run_seq(8'h04, 5'd2, 0, 0, 0, 0);
    run_seq(8'h04, 5'd2, 1, 1, 2, 1);
    check("coinc_isr", in_service_register, 8'h04);
    check("coinc_pr", priority_rotate, 2);

    // Reset in ACK1 aborts the sequence.
    do_reset();
    interrupt = 8'h08;
    tick();
    interrupt_acknowledge_n = 1'b0;
    tick();
    check("mid_isr", in_service_register, 8'h08);
    rst = 1'b0;
    #1;
    check_reset_values("mid_reset");
    interrupt = 8'd0;
    tick();
    rst = 1'b1;
    m_isr = 8'd0;
    m_pr = 7;
    m_dout = 8'd0;
    interrupt_acknowledge_n = 1'b1;
    tick();
    interrupt_acknowledge_n = 1'b0;
    tick();
    check("post_rst_en", data_out_en, 0);
    check("post_rst_clr", interrupt_request_clear, 0);
    tick();
    interrupt_acknowledge_n = 1'b1;
    tick();
    check("post_rst_en2", data_out_en, 0);
    check("post_rst_int", int_out, 0);
    tick();

`ifdef ISC_AUTO_EOI_EN
    do_reset();
    auto_eoi = 1'b1;
    rotate_on_eoi = 1'b0;
    run_seq(8'h01, 5'd4, 0, 0, 0, 0);
    check("auto_isr", in_service_register, 8'h00);
    run_seq(8'h00, 5'd4, 0, 0, 0, 0);
    auto_eoi = 1'b0;
`endif

    // Random mix of sequences and EOIs.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int op = $urandom_range(0, 2);
`ifdef ISC_AUTO_EOI_EN
      auto_eoi = 1'($urandom_range(0, 1));
`endif
      if (op < 2) begin
        int lvl = $urandom_range(0, 7);
        bit spur = ($urandom_range(0, 5) == 0);
        logic [7:0] irq = spur ? 8'd0 : (8'd1 << lvl);
        rotate_on_eoi = 1'($urandom_range(0, 1));
        run_seq(irq, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      end else begin
        do_eoi(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
